// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: FSM encodings, in-flight entry layout and
// the mispredict rule.
package branch_resolver_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [0:0] BR_NORMAL  = 1'b0;
  localparam logic [0:0] BR_RECOVER = 1'b1;

  // Bit layout: taken [64], target [63:32], fallthru [31:0].
  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fallthru;
  } br_entry_t;

  localparam int unsigned ENTRY_W = $bits(br_entry_t);

  function automatic logic is_mispredict(br_entry_t       head,
                                         logic            actual_taken,
                                         logic [PC_W-1:0] actual_target);
    return (head.taken != actual_taken) || (actual_taken && (head.target != actual_target));
  endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// Small FIFO holding in-flight predictions; supports push and pop in the same
// cycle (also when full) and a synchronous clear that wins over both.
module branch_pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks ID-stage predictions against MEM-stage outcomes; on a mismatch issues a
// registered flush/redirect, then ignores wrong-path traffic for a few cycles.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pred_valid,
  input  logic                 pred_taken,
  input  logic [PC_W-1:0]      pred_target,
  input  logic [PC_W-1:0]      pred_fallthru,
  input  logic                 stall,
  input  logic                 resolve_valid,
  input  logic                 actual_taken,
  input  logic [PC_W-1:0]      actual_target,
  output logic                 flush,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 upd_valid,
  output logic                 upd_taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  localparam int unsigned RcW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RECOVER_CYCLES - 1);

  logic [0:0]     state_q, state_d;
  logic [RcW-1:0] rec_cnt_q, rec_cnt_d;
  br_entry_t      head, new_entry;
  logic           fifo_full, fifo_empty;
  logic           normal, accept_pred, accept_res, res_ok, underflow, overflow, mispred;

  assign new_entry = '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};

  assign normal      = (state_q == BR_NORMAL);
  assign accept_pred = normal & pred_valid & ~stall;
  assign accept_res  = normal & resolve_valid & ~stall;
  assign res_ok      = accept_res & ~fifo_empty;
  assign underflow   = accept_res & fifo_empty;
  assign mispred     = res_ok & is_mispredict(head, actual_taken, actual_target);
  // A same-cycle dequeue frees the slot, so a full queue only overflows without one.
  assign overflow    = accept_pred & fifo_full & ~res_ok;

  branch_pred_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mispred),
    .push  (accept_pred & ~mispred),
    .pop   (res_ok),
    .wdata (new_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      BR_NORMAL: begin
        if (mispred) begin
          state_d   = BR_RECOVER;
          rec_cnt_d = '0;
        end
      end
      BR_RECOVER: begin
        // Advances regardless of stall.
        if (rec_cnt_q == RcLast) state_d = BR_NORMAL;
        else                     rec_cnt_d = rec_cnt_q + RcW'(1);
      end
      default: state_d = BR_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BR_NORMAL;
      rec_cnt_q     <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      flush     <= mispred;
      upd_valid <= res_ok;
      if (res_ok)  upd_taken   <= actual_taken;
      if (mispred) redirect_pc <= actual_taken ? actual_target : head.fallthru;
      if (res_ok && (branch_cnt != '1))   branch_cnt  <= branch_cnt + CNT_WIDTH'(1);
      if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
      if (underflow) err_underflow <= 1'b1;
      if (overflow)  err_overflow  <= 1'b1;
    end
  end

endmodule
